// File: rtl/zbus_pkg.sv
// zbus shared definitions: constant clog2, idle-bus fill value and parameter limits.
package zbus_pkg;

    // Smallest number of words a packing stage may group into one beat.
    localparam int unsigned RT_MIN = 2;

    // Fill value for buses that carry no valid data.
    localparam logic XZ = 1'bx;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/zbus_reg.sv
// zbus_reg: single-entry valid/ack output register. A load wins over an
// ack in the same cycle, so back-to-back beats leave no bubble.
module zbus_reg #(
    parameter int unsigned W = 32
) (
    input  logic         z_clk,
    input  logic         z_rst,
    input  logic         ld,
    input  logic [W-1:0] ld_bus,
    output logic         zo_vld,
    output logic [W-1:0] zo_bus,
    input  logic         zo_ack
);

    logic         vld_q;
    logic [W-1:0] bus_q;

    // Load, hold until acked, or clear after the beat is taken.
    always_ff @(posedge z_clk) begin
        if (z_rst) begin
            vld_q <= 1'b0;
            bus_q <= '0;
        end else if (ld) begin
            vld_q <= 1'b1;
            bus_q <= ld_bus;
        end else if (vld_q && zo_ack) begin
            vld_q <= 1'b0;
        end
    end

    assign zo_vld = vld_q;
    assign zo_bus = bus_q;

endmodule

// File: rtl/zbus_pack.sv
// zbus_pack: packs RT consecutive BW-bit zbus words into one BW*RT-bit beat,
// first-received word in the LSBs.
// Optional macro ZBUS_PACK_FLUSH_EN adds z_flush/zo_cnt for emitting partial groups.
module zbus_pack
    import zbus_pkg::*;
#(
    parameter  int unsigned BW = 8,
    parameter  int unsigned RT = 4,
    localparam int unsigned CW = clog2(RT)
) (
    input  logic             z_clk,
    input  logic             z_rst,
    input  logic             zi_vld,
    input  logic [BW-1:0]    zi_bus,
    output logic             zi_ack,
    output logic             zo_vld,
    output logic [BW*RT-1:0] zo_bus,
    input  logic             zo_ack
`ifdef ZBUS_PACK_FLUSH_EN
    ,
    input  logic             z_flush,
    output logic [CW:0]      zo_cnt
`endif
);

    if (RT < RT_MIN) begin : g_bad_rt
        $error("zbus_pack: RT must be >= 2");
    end

    localparam logic [CW-1:0] CntLast = CW'(RT - 1);
    localparam int unsigned   AW      = (RT - 1) * BW;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          last;
    logic          zi_trn;
    logic          full_ld;
    logic          ld;

    assign last    = (cnt_q == CntLast);
    // Only a completing word can stall, and only behind an un-acked beat.
    assign zi_ack  = !last || !zo_vld || zo_ack;
    assign zi_trn  = zi_vld && zi_ack;
    assign full_ld = zi_trn && last;

    // Word counter and accumulator next state.
    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (ld) begin
            cnt_d = '0;
        end else if (zi_trn) begin
            cnt_d = cnt_q + 1'b1;
        end
        for (int unsigned i = 0; i < RT - 1; i++) begin
            if (zi_trn && !last && cnt_q == CW'(i)) begin
                acc_d[i*BW +: BW] = zi_bus;
            end
        end
    end

    // Counter and accumulator registers.
    always_ff @(posedge z_clk) begin
        if (z_rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

`ifdef ZBUS_PACK_FLUSH_EN
    localparam int unsigned RW = BW * RT + CW + 1;

    logic             flush_q, flush_d;
    logic             flush_req;
    logic             flush_ld;
    logic [BW*RT-1:0] flush_bus;
    logic [CW:0]      ld_cnt;
    logic [RW-1:0]    ld_bus;
    logic [RW-1:0]    reg_bus;

    assign flush_req = flush_q || z_flush;
    // A same-cycle input word is absorbed first; the flush waits for a free cycle.
    assign flush_ld  = flush_req && !zi_trn && (cnt_q != '0) && (!zo_vld || zo_ack);
    assign ld        = full_ld || flush_ld;

    // Partial beat: held words in their lanes, unused lanes zeroed.
    always_comb begin
        flush_bus = '0;
        for (int unsigned i = 0; i < RT - 1; i++) begin
            if (CW'(i) < cnt_q) begin
                flush_bus[i*BW +: BW] = acc_q[i*BW +: BW];
            end
        end
    end

    // Sticky flush request; drops once served or found with nothing to flush.
    always_comb begin
        flush_d = flush_q;
        if (ld) begin
            flush_d = 1'b0;
        end else if (flush_req && !zi_trn && cnt_q == '0) begin
            flush_d = 1'b0;
        end else if (z_flush) begin
            flush_d = 1'b1;
        end
    end

    // Flush request register.
    always_ff @(posedge z_clk) begin
        if (z_rst) begin
            flush_q <= 1'b0;
        end else begin
            flush_q <= flush_d;
        end
    end

    assign ld_cnt = full_ld ? (CW + 1)'(RT) : {1'b0, cnt_q};
    assign ld_bus = {ld_cnt, (full_ld ? {zi_bus, acc_q} : flush_bus)};

    zbus_reg #(
        .W (RW)
    ) u_out (
        .z_clk  (z_clk),
        .z_rst  (z_rst),
        .ld     (ld),
        .ld_bus (ld_bus),
        .zo_vld (zo_vld),
        .zo_bus (reg_bus),
        .zo_ack (zo_ack)
    );

    assign zo_bus = reg_bus[BW*RT-1:0];
    assign zo_cnt = reg_bus[RW-1:BW*RT];
`else
    assign ld = full_ld;

    zbus_reg #(
        .W (BW * RT)
    ) u_out (
        .z_clk  (z_clk),
        .z_rst  (z_rst),
        .ld     (ld),
        .ld_bus ({zi_bus, acc_q}),
        .zo_vld (zo_vld),
        .zo_bus (zo_bus),
        .zo_ack (zo_ack)
    );
`endif

endmodule

// File: tb/tb_zbus_pack.sv
// Bench for zbus_pack (BW=8, RT=4): directed steps with a beat scoreboard.
// Covers the flush ports when ZBUS_PACK_FLUSH_EN is defined.
module tb_zbus_pack;

    localparam int unsigned BW = 8;
    localparam int unsigned RT = 4;

    logic        z_clk = 1'b0;
    logic        z_rst;
    logic        zi_vld;
    logic [7:0]  zi_bus;
    logic        zi_ack;
    logic        zo_vld;
    logic [31:0] zo_bus;
    logic        zo_ack;
`ifdef ZBUS_PACK_FLUSH_EN
    logic        z_flush;
    logic [2:0]  zo_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Scoreboard of beats expected from the output register, oldest first.
    logic [31:0] exp_q[$];
    logic [7:0]  m_acc [3];
    int          m_cnt = 0;

    always #5 z_clk = ~z_clk;

    zbus_pack #(
        .BW (BW),
        .RT (RT)
    ) dut (
        .z_clk   (z_clk),
        .z_rst   (z_rst),
        .zi_vld  (zi_vld),
        .zi_bus  (zi_bus),
        .zi_ack  (zi_ack),
        .zo_vld  (zo_vld),
        .zo_bus  (zo_bus),
        .zo_ack  (zo_ack)
`ifdef ZBUS_PACK_FLUSH_EN
        ,
        .z_flush (z_flush),
        .zo_cnt  (zo_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check at the falling edge, advance the model.
    task automatic cyc(input logic vld, input logic [7:0] d, input logic ack, output logic trn);
        logic exp_ack;
        logic mvld;
        zi_vld = vld;
        zi_bus = vld ? d : 8'hxx;
        zo_ack = ack;
`ifdef ZBUS_PACK_FLUSH_EN
        z_flush = 1'b0;
`endif
        @(negedge z_clk);
        mvld    = (exp_q.size() != 0);
        exp_ack = (m_cnt != RT - 1) || !mvld || ack;
        chk("zi_ack", zi_ack, exp_ack);
        chk("zo_vld", zo_vld, mvld);
        if (mvld) begin
            chk("zo_bus", zo_bus, exp_q[0]);
`ifdef ZBUS_PACK_FLUSH_EN
            chk("zo_cnt_full", zo_cnt, 3'd4);
`endif
            if (ack) void'(exp_q.pop_front());
        end
        trn = vld && exp_ack;
        if (trn) begin
            if (m_cnt == RT - 1) begin
                exp_q.push_back({d, m_acc[2], m_acc[1], m_acc[0]});
                m_cnt = 0;
            end else begin
                m_acc[m_cnt] = d;
                m_cnt++;
            end
        end
        @(posedge z_clk);
        #1;
    endtask

    // Offer a word until accepted, with a bounded number of attempts.
    task automatic send(input logic [7:0] d, input logic ack);
        logic trn;
        trn = 1'b0;
        for (int n = 0; n < 8 && !trn; n++) begin
            cyc(1'b1, d, ack, trn);
        end
        chk("send_accept", trn, 1'b1);
    endtask

    task automatic idle(input int n, input logic ack);
        logic trn;
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 8'h00, ack, trn);
        end
    endtask

    initial begin
        logic trn;

        // Reset with a valid word offered: nothing may be absorbed.
        z_rst  = 1'b1;
        zi_vld = 1'b1;
        zi_bus = 8'hAA;
        zo_ack = 1'b0;
`ifdef ZBUS_PACK_FLUSH_EN
        z_flush = 1'b0;
`endif
        @(posedge z_clk);
        @(negedge z_clk);
        chk("rst_zo_vld", zo_vld, 1'b0);
        chk("rst_zo_bus", zo_bus, 32'h0);
        @(posedge z_clk);
        #1;
        z_rst  = 1'b0;
        zi_vld = 1'b0;
        @(negedge z_clk);
        chk("rst_zi_ack", zi_ack, 1'b1);
        chk("post_rst_zo_vld", zo_vld, 1'b0);
        @(posedge z_clk);
        #1;

        // Streaming at full rate.
        for (int w = 0; w < 16; w++) begin
            send(8'(w), 1'b1);
            if (w == 3) begin
                chk("beat0_latency", zo_vld, 1'b1);
                chk("beat0_value", zo_bus, 32'h03020100);
            end
        end
        idle(2, 1'b1);

        // Backpressure: fill behind a pending beat, stall on the completing word.
        for (int w = 16; w < 20; w++) send(8'(w), 1'b1);
        for (int w = 20; w < 23; w++) send(8'(w), 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'd23, 1'b0, trn);
            chk("stall_zi_ack", zi_ack, 1'b0);
        end
        send(8'd23, 1'b1);
        chk("bp_no_bubble", zo_vld, 1'b1);
        chk("bp_beat", zo_bus, 32'h17161514);
        idle(2, 1'b1);

        // Ack arrives in the same cycle the next group completes.
        for (int w = 24; w < 28; w++) send(8'(w), 1'b1);
        for (int w = 28; w < 31; w++) send(8'(w), 1'b0);
        send(8'd31, 1'b1);
        chk("simul_vld", zo_vld, 1'b1);
        chk("simul_beat", zo_bus, 32'h1F1E1D1C);
        idle(1, 1'b0);
        idle(2, 1'b1);

        // Idle gaps between words; three words left in the accumulator.
        for (int w = 0; w < 19; w++) begin
            idle(int'($urandom_range(0, 2)), 1'b1);
            send(8'(w), 1'b1);
        end
        idle(4, 1'b1);
        chk("gap_partial_held", zo_vld, 1'b0);

        // Reset mid-fill discards the partial group.
        z_rst = 1'b1;
        @(posedge z_clk);
        #1;
        z_rst = 1'b0;
        m_cnt = 0;
        exp_q.delete();
        for (int w = 'h40; w < 'h44; w++) send(8'(w), 1'b1);
        chk("midfill_rst_beat", zo_bus, 32'h43424140);
        idle(2, 1'b1);

`ifdef ZBUS_PACK_FLUSH_EN
        // Flush a three-word partial group, then a flush with nothing held.
        for (int w = 'h10; w < 'h13; w++) send(8'(w), 1'b1);
        zi_vld  = 1'b0;
        zo_ack  = 1'b1;
        z_flush = 1'b1;
        @(posedge z_clk);
        #1;
        z_flush = 1'b0;
        chk("flush_vld", zo_vld, 1'b1);
        chk("flush_bus", zo_bus, 32'h00121110);
        chk("flush_cnt", zo_cnt, 3'd3);
        @(posedge z_clk);
        #1;
        chk("flush_taken", zo_vld, 1'b0);
        z_flush = 1'b1;
        @(posedge z_clk);
        #1;
        z_flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("flush_empty", zo_vld, 1'b0);
            @(posedge z_clk);
            #1;
        end
        m_cnt = 0;
        for (int w = 'h50; w < 'h54; w++) send(8'(w), 1'b1);
        idle(2, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
